// File: rtl/fft_stim_gen.sv
// Frame-based complex stimulus source for the FFT input buffer: emits 2^N_LOG2-sample
// frames of a selectable pattern with start/over flags, valid/ready handshake and inter-frame gaps.
module fft_stim_gen #(
    parameter int N_LOG2     = 4,
    parameter int DATA_W     = 32,
    parameter int GAP        = 2,
    parameter int NUM_FRAMES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] amp,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_real,
    output logic [DATA_W-1:0] data_img,
    output logic              valid,
    output logic              start,
    output logic              over,
    output logic [15:0]       frame_idx,
    output logic              done
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [N_LOG2-1:0] K_LAST     = '1;
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0]       FRAME_LAST = 16'((NUM_FRAMES > 0) ? NUM_FRAMES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;
    typedef enum logic [1:0] {M_RAMP, M_IMPULSE, M_CONST, M_ALT} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [DATA_W-1:0] amp_q, amp_d;
    logic [N_LOG2-1:0] k_q, k_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] data_real_q, data_real_d;
    logic [DATA_W-1:0] data_img_q, data_img_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              over_q, over_d;
    logic [15:0]       frame_idx_q, frame_idx_d;
    logic              done_q, done_d;

    logic [N_LOG2-1:0] k_next;
    logic              begin_frame;

    function automatic logic [DATA_W-1:0] pattern_real(input mode_t m,
                                                       input logic [DATA_W-1:0] a,
                                                       input logic [N_LOG2-1:0] k);
        logic [DATA_W-1:0] k_ext;
        k_ext = DATA_W'(k);
        case (m)
            M_RAMP:    return a + k_ext;
            M_IMPULSE: return (k == '0) ? a : '0;
            M_CONST:   return a;
            default:   return k[0] ? -a : a;
        endcase
    endfunction

    // N-1-k within the frame-index width is simply the bitwise inverse of k.
    function automatic logic [DATA_W-1:0] pattern_img(input mode_t m,
                                                      input logic [N_LOG2-1:0] k);
        logic [N_LOG2-1:0] k_inv;
        k_inv = ~k;
        return (m == M_RAMP) ? DATA_W'(k_inv) : '0;
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        amp_d       = amp_q;
        k_d         = k_q;
        gap_cnt_d   = gap_cnt_q;
        data_real_d = data_real_q;
        data_img_d  = data_img_q;
        valid_d     = valid_q;
        start_d     = start_q;
        over_d      = over_q;
        frame_idx_d = frame_idx_q;
        done_d      = done_q;
        begin_frame = 1'b0;
        k_next      = k_q + N_LOG2'(1);

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                start_d = 1'b0;
                over_d  = 1'b0;
                done_d  = 1'b0;
                if (enable) begin
                    begin_frame = 1'b1;
                    frame_idx_d = '0;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (k_q != K_LAST) begin
                        k_d         = k_next;
                        data_real_d = pattern_real(mode_q, amp_q, k_next);
                        data_img_d  = pattern_img(mode_q, k_next);
                        start_d     = 1'b0;
                        over_d      = (k_next == K_LAST);
                    end else begin
                        valid_d = 1'b0;
                        start_d = 1'b0;
                        over_d  = 1'b0;
                        if (NUM_FRAMES != 0 && frame_idx_q == FRAME_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (!enable) begin
                            state_d = S_IDLE;
                        end else if (GAP > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            begin_frame = 1'b1;
                            frame_idx_d = frame_idx_q + 16'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (enable) begin
                        begin_frame = 1'b1;
                        frame_idx_d = frame_idx_q + 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
        endcase

        // Pattern inputs are captured only here, so a frame never mixes modes or amplitudes.
        if (begin_frame) begin
            state_d     = S_RUN;
            mode_d      = mode_t'(mode);
            amp_d       = amp;
            k_d         = '0;
            data_real_d = pattern_real(mode_t'(mode), amp, '0);
            data_img_d  = pattern_img(mode_t'(mode), '0);
            valid_d     = 1'b1;
            start_d     = 1'b1;
            over_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M_RAMP;
            amp_q       <= '0;
            k_q         <= '0;
            gap_cnt_q   <= '0;
            data_real_q <= '0;
            data_img_q  <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            over_q      <= 1'b0;
            frame_idx_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            amp_q       <= amp_d;
            k_q         <= k_d;
            gap_cnt_q   <= gap_cnt_d;
            data_real_q <= data_real_d;
            data_img_q  <= data_img_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            over_q      <= over_d;
            frame_idx_q <= frame_idx_d;
            done_q      <= done_d;
        end
    end

    assign data_real = data_real_q;
    assign data_img  = data_img_q;
    assign valid     = valid_q;
    assign start     = start_q;
    assign over      = over_q;
    assign frame_idx = frame_idx_q;
    assign done      = done_q;

endmodule
